// File: rtl/filter_select_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : filter_select_ctrl_if                                      |
// | Description : Config-word valid/ready bus between the selection          |
// |               controller and the filter/coefficient datapath.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface filter_select_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_field;
    logic [2:0] cfg_value;

    modport master (
        output cfg_valid,
        output cfg_field,
        output cfg_value,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_field,
        input  cfg_value,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/filter_select_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : filter_select_ctrl                                         |
// | Description : Synchronises/debounces a 4-bit button code, decodes it     |
// |               into EQ freq / lowpass / highpass selections and applies   |
// |               each change through a config handshake. Optional macro     |
// |               FILTER_CTRL_SOFT_MUTE_EN adds tick-timed mute/unmute waits.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module filter_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int MUTE_SAMPLES    = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [3:0]       buttons,
    input  wire logic             sample_tick,
    filter_select_ctrl_if.master  cfg,
    output logic      [2:0]       freq_select,
    output logic      [2:0]       lowpass_select,
    output logic      [2:0]       highpass_select,
    output logic                  mute,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] c_CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       c_FIELD_FREQ = 2'b00;
    localparam logic [1:0]       c_FIELD_LP   = 2'b01;
    localparam logic [1:0]       c_FIELD_HP   = 2'b10;
    localparam logic [3:0]       c_RST_CODE   = 4'd5;

`ifdef FILTER_CTRL_SOFT_MUTE_EN
    localparam int                c_TICK_W    = (MUTE_SAMPLES > 1) ? $clog2(MUTE_SAMPLES) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(MUTE_SAMPLES - 1);
`else
    localparam int c_unused_mute_samples = MUTE_SAMPLES;
    logic          w_unused_tick;
    assign w_unused_tick = sample_tick;
`endif

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
`ifdef FILTER_CTRL_SOFT_MUTE_EN
        ST_MUTE_WAIT   = 2'd1,
        ST_UNMUTE_WAIT = 2'd3,
`endif
        ST_LOAD        = 2'd2
    } state_t;

    // Synchroniser and debounce
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       cand_q;
    logic [3:0]       last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_commit;
    logic [1:0]       w_commit_field;
    logic [2:0]       w_commit_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= c_RST_CODE;
            cnt_q   <= '0;
            last_q  <= c_RST_CODE;
        end else begin
            sync1_q <= buttons;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q < c_CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (w_commit) begin
                last_q <= cand_q;
            end
        end
    end

    // Saturating counter plus last_q compare makes a held code commit once
    assign w_commit = (sync2_q == cand_q) && (cnt_q == c_CNT_MAX) && (cand_q != last_q);

    always_comb begin
        w_commit_field = c_FIELD_FREQ;
        w_commit_value = cand_q[2:0];
        if (cand_q[3]) begin
            w_commit_field = cand_q[2] ? c_FIELD_HP : c_FIELD_LP;
            w_commit_value = {1'b0, cand_q[1:0]};
        end
    end

    // Sequencer state
    state_t     state_q;
    logic       valid_q;
    logic [1:0] field_q;
    logic [2:0] value_q;
    logic [2:0] freq_q;
    logic [2:0] lp_q;
    logic [2:0] hp_q;
    logic       mute_q;
    logic       busy_q;
    logic       pend_q;
    logic [1:0] pend_field_q;
    logic [2:0] pend_value_q;
`ifdef FILTER_CTRL_SOFT_MUTE_EN
    logic [c_TICK_W-1:0] tick_cnt_q;
`endif

    // A fresh commit is newer than any pending entry, so it takes priority
    logic       w_req;
    logic [1:0] w_req_field;
    logic [2:0] w_req_value;
    logic [2:0] w_cur_sel;

    assign w_req       = w_commit || pend_q;
    assign w_req_field = w_commit ? w_commit_field : pend_field_q;
    assign w_req_value = w_commit ? w_commit_value : pend_value_q;

    always_comb begin
        w_cur_sel = freq_q;
        case (w_req_field)
            c_FIELD_LP: w_cur_sel = lp_q;
            c_FIELD_HP: w_cur_sel = hp_q;
            default:    w_cur_sel = freq_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            field_q      <= '0;
            value_q      <= '0;
            freq_q       <= 3'd5;
            lp_q         <= '0;
            hp_q         <= '0;
            mute_q       <= 1'b0;
            busy_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_field_q <= '0;
            pend_value_q <= '0;
`ifdef FILTER_CTRL_SOFT_MUTE_EN
            tick_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        pend_q <= 1'b0;
                        if (w_req_value != w_cur_sel) begin
                            field_q <= w_req_field;
                            value_q <= w_req_value;
                            busy_q  <= 1'b1;
`ifdef FILTER_CTRL_SOFT_MUTE_EN
                            state_q    <= ST_MUTE_WAIT;
                            mute_q     <= 1'b1;
                            tick_cnt_q <= '0;
`else
                            state_q    <= ST_LOAD;
                            valid_q    <= 1'b1;
`endif
                        end
                    end
                end
`ifdef FILTER_CTRL_SOFT_MUTE_EN
                ST_MUTE_WAIT: begin
                    if (sample_tick) begin
                        if (tick_cnt_q == c_TICK_LAST) begin
                            tick_cnt_q <= '0;
                            state_q    <= ST_LOAD;
                            valid_q    <= 1'b1;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + c_TICK_W'(1);
                        end
                    end
                end
                ST_UNMUTE_WAIT: begin
                    if (sample_tick) begin
                        if (tick_cnt_q == c_TICK_LAST) begin
                            tick_cnt_q <= '0;
                            state_q    <= ST_IDLE;
                            mute_q     <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + c_TICK_W'(1);
                        end
                    end
                end
`endif
                ST_LOAD: begin
                    if (valid_q && cfg.cfg_ready) begin
                        case (field_q)
                            c_FIELD_LP: lp_q   <= value_q;
                            c_FIELD_HP: hp_q   <= value_q;
                            default:    freq_q <= value_q;
                        endcase
                        valid_q <= 1'b0;
`ifdef FILTER_CTRL_SOFT_MUTE_EN
                        state_q    <= ST_UNMUTE_WAIT;
                        tick_cnt_q <= '0;
`else
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Commits arriving mid-sequence park here, latest overwrites
            if (w_commit && (state_q != ST_IDLE)) begin
                pend_q       <= 1'b1;
                pend_field_q <= w_commit_field;
                pend_value_q <= w_commit_value;
            end
        end
    end

    assign cfg.cfg_valid    = valid_q;
    assign cfg.cfg_field    = field_q;
    assign cfg.cfg_value    = value_q;
    assign freq_select      = freq_q;
    assign lowpass_select   = lp_q;
    assign highpass_select  = hp_q;
    assign mute             = mute_q;
    assign busy             = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_filter_select_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_filter_select_ctrl                                      |
// | Description : Directed self-checking bench for filter_select_ctrl with a |
// |               cycle-level behavioural model and literal spot checks.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_filter_select_ctrl;

    localparam int D           = 4;
    localparam int M           = 2;
    localparam int TICK_PERIOD = 8;
`ifdef FILTER_CTRL_SOFT_MUTE_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [3:0] buttons = 4'd5;
    logic       tick    = 1'b0;
    logic       ready   = 1'b0;
    logic [2:0] freq_o;
    logic [2:0] lp_o;
    logic [2:0] hp_o;
    logic       mute_o;
    logic       busy_o;

    int n_cmp  = 0;
    int n_bad  = 0;
    int dut_hs = 0;
    bit chk_en = 1'b0;

    filter_select_ctrl_if cfg_bus();
    assign cfg_bus.cfg_ready = ready;

    filter_select_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4),
        .MUTE_SAMPLES    (M)
    ) dut (
        .clk             (clk),
        .reset           (rst),
        .buttons         (buttons),
        .sample_tick     (tick),
        .cfg             (cfg_bus),
        .freq_select     (freq_o),
        .lowpass_select  (lp_o),
        .highpass_select (hp_o),
        .mute            (mute_o),
        .busy            (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            div  = (div + 1) % TICK_PERIOD;
            tick = (div == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fld(input int code);
        return (code < 8) ? 0 : ((code < 12) ? 1 : 2);
    endfunction

    function automatic int val(input int code);
        return (code < 8) ? code : ((code < 12) ? code - 8 : code - 12);
    endfunction

    // Model: phase 0 idle, 1 mute wait, 2 load, 3 unmute wait
    int m_b1, m_b2, m_run_code, m_run_len, m_last, m_pend_code;
    int m_phase, m_left, m_cur;
    bit m_pend;
    int m_sel [3];

    always @(posedge clk) begin : model
        int s;
        int req;
        int phase_now;
        bit commit;
        if (rst) begin
            m_b1 = 0; m_b2 = 0;
            m_run_code = 5; m_run_len = 1; m_last = 5;
            m_pend = 1'b0; m_pend_code = 0;
            m_phase = 0; m_left = 0; m_cur = 0;
            m_sel[0] = 5; m_sel[1] = 0; m_sel[2] = 0;
        end else begin
            s    = m_b2;
            m_b2 = m_b1;
            m_b1 = int'(buttons);
            if (s == m_run_code) begin
                if (m_run_len < 1000) m_run_len++;
            end else begin
                m_run_code = s;
                m_run_len  = 1;
            end
            // A code seen on D+1 consecutive synced cycles is accepted once
            commit = (m_run_len == D + 1) && (m_run_code != m_last);
            if (commit) m_last = m_run_code;
            phase_now = m_phase;
            case (m_phase)
                0: if (commit || m_pend) begin
                    req    = commit ? m_run_code : m_pend_code;
                    m_pend = 1'b0;
                    if (val(req) != m_sel[fld(req)]) begin
                        m_cur   = req;
                        m_phase = SOFT ? 1 : 2;
                        m_left  = M;
                    end
                end
                1: if (tick) begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: if (ready) begin
                    m_sel[fld(m_cur)] = val(m_cur);
                    m_phase = SOFT ? 3 : 0;
                    m_left  = M;
                end
                default: if (tick) begin
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
            endcase
            if (commit && phase_now != 0) begin
                m_pend      = 1'b1;
                m_pend_code = m_run_code;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy_o, m_phase != 0);
            chk("mute", mute_o, SOFT && (m_phase != 0));
            chk("cfg_valid", cfg_bus.cfg_valid, m_phase == 2);
            if (m_phase == 2) begin
                chk("cfg_field", cfg_bus.cfg_field, fld(m_cur));
                chk("cfg_value", cfg_bus.cfg_value, val(m_cur));
            end
            chk("freq_select", freq_o, m_sel[0]);
            chk("lowpass_select", lp_o, m_sel[1]);
            chk("highpass_select", hp_o, m_sel[2]);
            if (cfg_bus.cfg_valid === 1'b1 && ready) dut_hs++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (busy_o !== lvl && n < budget) begin
            step();
            n++;
        end
        chk(name, busy_o, lvl);
    endtask

    initial begin : stim
        int hs0;
        int n;
        rst = 1'b1; buttons = 4'd5; ready = 1'b0;
        repeat (2) step();
        chk_en = 1'b1;
        chk("rst_freq", freq_o, 5);
        chk("rst_lp", lp_o, 0);
        chk("rst_hp", hp_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_mute", mute_o, 0);
        chk("rst_valid", cfg_bus.cfg_valid, 0);
        rst = 1'b0;

        // Reset code held: nothing commits
        repeat (100) step();
        chk("hold5_hs", dut_hs, 0);
        chk("hold5_busy", busy_o, 0);

        // Code 8 equals current lowpass 0: dropped
        buttons = 4'd8;
        repeat (30) step();
        chk("drop_hs", dut_hs, 0);
        chk("drop_busy", busy_o, 0);

        // Code 9 -> lowpass 1
        hs0 = dut_hs; ready = 1'b1; buttons = 4'd9;
        wait_busy(1'b1, 60, "t2_start");
        chk("t2_mute", mute_o, SOFT);
        wait_busy(1'b0, 200, "t2_end");
        chk("t2_lp", lp_o, 1);
        chk("t2_freq", freq_o, 5);
        chk("t2_hp", hp_o, 0);
        chk("t2_hs", dut_hs - hs0, 1);

        // Bouncing 13/14 never settles, then 14 held
        hs0 = dut_hs;
        for (int i = 0; i < 20; i++) begin
            buttons = (i % 2) ? 4'd14 : 4'd13;
            step();
            step();
        end
        chk("t3_bounce_busy", busy_o, 0);
        chk("t3_bounce_hs", dut_hs - hs0, 0);
        buttons = 4'd14;
        wait_busy(1'b1, 60, "t3_start");
        wait_busy(1'b0, 200, "t3_end");
        chk("t3_hp", hp_o, 2);
        chk("t3_hs", dut_hs - hs0, 1);

        // Two commits during a sequence: only the latest (6) is replayed
        hs0 = dut_hs; ready = 1'b0; buttons = 4'd2;
        wait_busy(1'b1, 60, "t4_start");
        buttons = 4'd3;
        repeat (12) step();
        buttons = 4'd6;
        repeat (12) step();
        ready = 1'b1;
        n = 0;
        while (!(freq_o == 3'd6 && busy_o == 1'b0) && n < 300) begin
            step();
            n++;
        end
        chk("t4_freq", freq_o, 6);
        chk("t4_hs", dut_hs - hs0, 2);

        // Stalled handshake keeps the word stable
        hs0 = dut_hs; ready = 1'b0; buttons = 4'd10;
        n = 0;
        while (cfg_bus.cfg_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        for (int i = 0; i < 50; i++) begin
            chk("t5_valid", cfg_bus.cfg_valid, 1);
            chk("t5_field", cfg_bus.cfg_field, 1);
            chk("t5_value", cfg_bus.cfg_value, 2);
            chk("t5_mute", mute_o, SOFT);
            step();
        end
        chk("t5_lp_before", lp_o, 1);
        ready = 1'b1;
        wait_busy(1'b0, 200, "t5_end");
        chk("t5_lp", lp_o, 2);
        chk("t5_hs", dut_hs - hs0, 1);

        // Reset mid-sequence discards the selection
        ready = 1'b0; buttons = 4'd4;
        wait_busy(1'b1, 60, "rst_seq_start");
        step();
        rst = 1'b1; buttons = 4'd5;
        step();
        rst = 1'b0;
        chk("rstseq_busy", busy_o, 0);
        chk("rstseq_mute", mute_o, 0);
        chk("rstseq_valid", cfg_bus.cfg_valid, 0);
        chk("rstseq_freq", freq_o, 5);
        chk("rstseq_lp", lp_o, 0);
        chk("rstseq_hp", hp_o, 0);
        repeat (20) step();
        chk("rstseq_idle", busy_o, 0);

        // Highpass 3 then back to 0 via code 12
        ready = 1'b1; buttons = 4'd15;
        wait_busy(1'b1, 60, "t6a_start");
        wait_busy(1'b0, 200, "t6a_end");
        chk("t6_hp3", hp_o, 3);
        buttons = 4'd12;
        wait_busy(1'b1, 60, "t6b_start");
        chk("t6_mute", mute_o, SOFT);
        wait_busy(1'b0, 200, "t6b_end");
        chk("t6_hp0", hp_o, 0);
        chk("t6_mute_end", mute_o, 0);
        chk("t6_freq", freq_o, 5);

        repeat (3) step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
